// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding word reads into a small prefetch FIFO,
// presented to decode with valid/ready; redirects to i_pc on flush.
module fetch_unit #(
    parameter int            RW         = 16,
    parameter int            FIFO_DEPTH = 2,
    parameter logic [RW-1:0] RESET_ADDR = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [RW-1:0] i_pc,
    input  logic          i_flush,
    output logic          o_mem_req,
    output logic [RW-1:0] o_mem_addr,
    input  logic          i_mem_ack,
    input  logic [RW-1:0] i_mem_data,
    output logic          o_valid,
    output logic [RW-1:0] o_instr,
    output logic [RW-1:0] o_instr_addr,
    input  logic          i_ready,
    output logic          o_c_pc_inc
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic          req_q, req_d;
    logic [RW-1:0] addr_q, addr_d;
    logic [RW-1:0] fetch_q, fetch_d;
    logic          discard_q, discard_d;

    logic [RW-1:0] data_mem [FIFO_DEPTH];
    logic [RW-1:0] addr_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;

    logic ack, push, pop;

    // An ack only counts against a live request; flush and discard both drop the word.
    assign ack  = i_mem_ack & req_q;
    assign push = ack & ~discard_q & ~i_flush;
    assign pop  = o_valid & i_ready & ~i_flush;

    assign o_valid      = (count != '0);
    assign o_instr      = data_mem[rd_ptr];
    assign o_instr_addr = addr_mem[rd_ptr];
    assign o_c_pc_inc   = pop;
    assign o_mem_req    = req_q;
    assign o_mem_addr   = addr_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_next = count;
        if (i_flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_comb begin
        req_d     = req_q;
        addr_d    = addr_q;
        fetch_d   = fetch_q;
        discard_d = discard_q;
        if (req_q) begin
            if (ack) begin
                req_d     = 1'b0;
                discard_d = 1'b0;
                if (i_flush) begin
                    fetch_d = i_pc;
                end else if (!discard_q) begin
                    fetch_d = addr_q + RW'(1);
                    // Chain straight into the next word when the FIFO still has room.
                    if (count_next < DEPTH_C) begin
                        req_d  = 1'b1;
                        addr_d = addr_q + RW'(1);
                    end
                end
            end else if (i_flush) begin
                fetch_d   = i_pc;
                discard_d = 1'b1;
            end
        end else if (i_flush) begin
            fetch_d = i_pc;
        end else if (!discard_q && count_next < DEPTH_C) begin
            req_d  = 1'b1;
            addr_d = fetch_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_q     <= 1'b0;
            addr_q    <= RESET_ADDR;
            fetch_q   <= RESET_ADDR;
            discard_q <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            req_q     <= req_d;
            addr_q    <= addr_d;
            fetch_q   <= fetch_d;
            discard_q <= discard_d;
            count     <= count_next;
            if (i_flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: FIFO storage has no reset; entries are only observed once count marks them valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem[wr_ptr] <= i_mem_data;
            addr_mem[wr_ptr] <= addr_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, directed scenarios, random run,
// and a scoreboard that expects the sequential word stream starting at each redirect target.
module tb_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_pc = '0;
    logic        i_flush = 1'b0;
    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic        i_mem_ack = 1'b0;
    logic [15:0] i_mem_data = '0;
    logic        o_valid;
    logic [15:0] o_instr;
    logic [15:0] o_instr_addr;
    logic        i_ready = 1'b0;
    logic        o_c_pc_inc;

    fetch_unit #(.RW(16), .FIFO_DEPTH(2), .RESET_ADDR(16'h0000)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc(i_pc), .i_flush(i_flush),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
        .o_valid(o_valid), .o_instr(o_instr), .o_instr_addr(o_instr_addr),
        .i_ready(i_ready), .o_c_pc_inc(o_c_pc_inc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } word_t;

    logic [15:0] mem [65536];
    word_t       exp_q [$];
    logic [15:0] exp_next;
    logic [15:0] req_log [$];

    int checks = 0;
    int errors = 0;
    int delivered = 0;

    int          credits = -1;
    int          ack_delay = 0;
    bit          stray_en = 1'b0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [15:0] prev_addr = '0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference program stream: after a redirect to P, decode sees P, P+1, ... (mod 2^16).
    function automatic void refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{addr: exp_next, data: mem[exp_next]});
            exp_next = exp_next + 16'd1;
        end
    endfunction

    function automatic void redirect(input logic [15:0] pc);
        exp_q.delete();
        exp_next = pc;
        refill();
    endfunction

    // Monitor: every accepted word is popped from the scoreboard and compared.
    always @(negedge i_clk) begin : monitor
        word_t w;
        if (i_rst_n) begin
            if (o_valid && i_ready && !i_flush) begin
                check("pc_inc_on_accept", 32'(o_c_pc_inc), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got addr %0h expected none", o_instr_addr);
                end else begin
                    w = exp_q.pop_front();
                    check("instr_addr", 32'(o_instr_addr), 32'(w.addr));
                    check("instr_data", 32'(o_instr), 32'(w.data));
                    delivered++;
                    refill();
                end
            end else begin
                check("pc_inc_idle", 32'(o_c_pc_inc), 32'd0);
            end
        end
    end

    // Memory model: acks after ack_delay cycles of a held request, limited by credits.
    task automatic respond();
        if (!i_rst_n) begin
            i_mem_ack = 1'b0;
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
            return;
        end
        if (prev_req && !prev_ack)
            check("req_held", 32'({o_mem_req, o_mem_addr}), 32'({1'b1, prev_addr}));
        if (o_mem_req) begin
            if (!prev_req || prev_ack) wait_cnt = 0;
            else wait_cnt++;
            if (wait_cnt >= ack_delay && credits != 0) begin
                i_mem_ack  = 1'b1;
                i_mem_data = mem[o_mem_addr];
                req_log.push_back(o_mem_addr);
                if (credits > 0) credits--;
                prev_ack = 1'b1;
            end else begin
                i_mem_ack  = 1'b0;
                i_mem_data = 16'($urandom);
                prev_ack   = 1'b0;
            end
        end else begin
            i_mem_ack  = stray_en && ($urandom_range(0, 3) == 0);
            i_mem_data = 16'($urandom);
            prev_ack   = 1'b0;
        end
        prev_req  = o_mem_req;
        prev_addr = o_mem_addr;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        respond();
    endtask

    task automatic do_reset(input bit with_flush, input logic [15:0] pc);
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        redirect(16'h0000);
        #1;
        check("rst_req", 32'(o_mem_req), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_addr", 32'(o_mem_addr), 32'h0000);
        step();
        step();
        req_log.delete();
        i_rst_n = 1'b1;
        if (with_flush) begin
            i_flush = 1'b1;
            i_pc    = pc;
            redirect(pc);
        end
        step();
        i_flush = 1'b0;
    endtask

    task automatic wait_req(input logic [15:0] a);
        int n = 0;
        while (!(o_mem_req && o_mem_addr == a) && n < 20) begin
            step();
            n++;
        end
        check("wait_req", 32'({o_mem_req, o_mem_addr}), 32'({1'b1, a}));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

        // Streaming from reset, ack one cycle after each request is raised.
        credits = -1; ack_delay = 1; stray_en = 1'b0;
        do_reset(1'b0, 16'h0000);
        check("first_req_after_reset", 32'({o_mem_req, o_mem_addr}), 32'({1'b1, 16'h0000}));
        i_ready = 1'b1;
        base = delivered;
        repeat (12) step();
        check("stream_len_ok", 32'(req_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            check("stream_addr", 32'(req_log[i]), 32'(i));
        check("stream_delivered", 32'(delivered - base >= 4), 32'd1);

        // Decode stalled: FIFO fills with exactly two words, then one pop frees one fetch.
        ack_delay = 0;
        do_reset(1'b0, 16'h0000);
        repeat (20) step();
        check("full_fetch_count", 32'(req_log.size()), 32'd2);
        check("full_req_low", 32'(o_mem_req), 32'd0);
        check("full_valid", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        repeat (10) step();
        check("refetch_count", 32'(req_log.size()), 32'd3);
        if (req_log.size() == 3) check("refetch_addr", 32'(req_log[2]), 32'h0002);
        check("refetch_req_low", 32'(o_mem_req), 32'd0);

        // Flush while a request is outstanding: stale ack must be discarded.
        credits = 0;
        do_reset(1'b1, 16'h0005);
        wait_req(16'h0005);
        i_flush = 1'b1; i_pc = 16'h0100; i_ready = 1'b1;
        redirect(16'h0100);
        step();
        i_flush = 1'b0;
        repeat (3) begin
            check("stale_req_held", 32'({o_mem_req, o_mem_addr}), 32'({1'b1, 16'h0005}));
            check("no_valid_while_discard", 32'(o_valid), 32'd0);
            step();
        end
        req_log.delete();
        credits = -1;
        base = delivered;
        wait_req(16'h0100);
        if (req_log.size() > 0) check("stale_ack_addr", 32'(req_log[0]), 32'h0005);
        repeat (10) step();
        check("after_discard_delivered", 32'(delivered - base >= 2), 32'd1);

        // Flush in the same cycle as an ack, with a word available to decode.
        credits = 1;
        do_reset(1'b1, 16'h000F);
        wait_req(16'h0010);
        check("pre_flush_valid", 32'(o_valid), 32'd1);
        credits = 1;
        step();
        i_flush = 1'b1; i_pc = 16'h0200; i_ready = 1'b1;
        redirect(16'h0200);
        #3;
        check("pc_inc_during_flush", 32'(o_c_pc_inc), 32'd0);
        step();
        i_flush = 1'b0;
        check("flush_ack_fifo_empty", 32'(o_valid), 32'd0);
        check("flush_ack_req_low", 32'(o_mem_req), 32'd0);
        credits = -1;
        step();
        check("flush_ack_next_req", 32'({o_mem_req, o_mem_addr}), 32'({1'b1, 16'h0200}));
        repeat (10) step();

        // Address wrap at the top of the space.
        do_reset(1'b1, 16'hFFFF);
        i_ready = 1'b1;
        repeat (10) step();
        if (req_log.size() >= 2) begin
            check("wrap_addr_ffff", 32'(req_log[0]), 32'h0000FFFF);
            check("wrap_addr_0000", 32'(req_log[1]), 32'h00000000);
        end else begin
            check("wrap_req_count", 32'(req_log.size()), 32'd2);
        end

        // Asynchronous reset with a request outstanding and a buffered word.
        do_reset(1'b0, 16'h0000);
        credits = 2;
        repeat (8) step();
        check("pre_rst_full", 32'({o_valid, o_mem_req}), 32'({1'b1, 1'b0}));
        credits = 0;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        step();
        check("pre_rst_busy", 32'({o_valid, o_mem_req}), 32'({1'b1, 1'b1}));
        #3;
        i_rst_n = 1'b0;
        redirect(16'h0000);
        #1;
        check("async_rst_req", 32'(o_mem_req), 32'd0);
        check("async_rst_valid", 32'(o_valid), 32'd0);
        step();
        step();
        req_log.delete();
        credits = -1;
        i_rst_n = 1'b1;
        i_mem_ack = 1'b1;
        i_mem_data = 16'hDEAD;
        step();
        check("post_rst_req", 32'({o_mem_req, o_mem_addr}), 32'({1'b1, 16'h0000}));
        i_ready = 1'b1;
        repeat (8) step();

        // Randomized traffic: stalls, variable latency, stray acks and redirects.
        do_reset(1'b0, 16'h0000);
        credits = -1;
        stray_en = 1'b1;
        base = delivered;
        for (int c = 0; c < 4000; c++) begin
            ack_delay = $urandom_range(0, 2);
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin
                i_flush = 1'b1;
                i_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
                redirect(i_pc);
            end else begin
                i_flush = 1'b0;
            end
            step();
        end
        i_flush = 1'b0;
        step();
        step();
        check("random_progress", 32'(delivered - base > 400), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
